// File: rtl/aes_pkg.sv
// Shared definitions for the multi-length AES key schedule.
//   - Nk/Nr constants per key length and the key_len encodings
//   - Key-schedule FSM state type
//   - S-box lookup and GF(2^8) xtime helpers
package aes_pkg;

    localparam int NK_128 = 4;
    localparam int NK_192 = 6;
    localparam int NK_256 = 8;
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    localparam logic [1:0] KEY_LEN_128  = 2'b00;
    localparam logic [1:0] KEY_LEN_192  = 2'b01;
    localparam logic [1:0] KEY_LEN_256  = 2'b10;
    localparam logic [1:0] KEY_LEN_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_t;

    // Index 0 is the most significant byte, so SBOX[b] reads row-major.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: return 4'(NK_192);
            KEY_LEN_256: return 4'(NK_256);
            default:     return 4'(NK_128);
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] len);
        case (len)
            KEY_LEN_192: return 4'(NR_192);
            KEY_LEN_256: return 4'(NR_256);
            default:     return 4'(NR_128);
        endcase
    endfunction

endpackage

// File: rtl/aes_subword.sv
// Combinational SubWord: S-box applied to each byte of a 32-bit word.
//   word_in  in  32  word to substitute
//   word_out out 32  substituted word
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    assign word_out = {sbox(word_in[31:24]), sbox(word_in[23:16]),
                       sbox(word_in[15:8]),  sbox(word_in[7:0])};

endmodule

// File: rtl/aes_key_schedule_multi.sv
// Word-serial AES key expansion for 128/192/256-bit keys with a round-key
// store that serves any round key in encrypt or decrypt order.
//   clk, rst            clock; synchronous active-low reset
//   start/key_len/key_in  begin expansion (key left-justified in key_in)
//   busy/ready/cfg_err/nr status: expanding, store valid, reserved-length pulse, Nr
//   rd_en/rd_dir/rd_round read request (rd_dir=1 serves round nr-rd_round)
//   rd_key/rd_valid       registered read data, valid one cycle after request
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no key expanded since reset
// ST_EXPAND | generating one word w[i] per cycle
// ST_DONE   | store holds every round key of the latched key
module aes_key_schedule_multi
    import aes_pkg::*;
#(
    parameter int MAX_KEY_BITS = 256,
    parameter int ROUND_BITS   = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              key_len,
    input  logic [MAX_KEY_BITS-1:0] key_in,
    output logic                    busy,
    output logic                    ready,
    output logic                    cfg_err,
    output logic [3:0]              nr,
    input  logic                    rd_en,
    input  logic                    rd_dir,
    input  logic [3:0]              rd_round,
    output logic [ROUND_BITS-1:0]   rd_key,
    output logic                    rd_valid
);

    localparam int MAX_NK      = MAX_KEY_BITS / 32;
    localparam int MAX_NR      = MAX_NK + 6;
    localparam int STORE_DEPTH = 4 * (MAX_NR + 1);

    ks_state_t   state_q, state_d;
    logic [3:0]  nk_q, nr_q;
    logic [5:0]  i_q;
    logic [2:0]  mod_q;
    logic [7:0]  rcon_q;
    logic [31:0] w [STORE_DEPTH];

    logic        len_ok, start_acc, word_wr, rd_ok;
    logic [5:0]  total, rd_base;
    logic [3:0]  rd_eff;
    logic [31:0] w_prev, w_back, rot_prev, sub_in, sub_out, t_word, new_word;

    // Lengths wider than the store was built for are rejected like the reserved code.
    assign len_ok    = (key_len != KEY_LEN_RSVD) &&
                       (32 * int'(nk_of(key_len)) <= MAX_KEY_BITS);
    assign start_acc = start && (state_q != ST_EXPAND) && len_ok;
    assign total     = {nr_q + 4'd1, 2'b00};
    // i reaches total one edge after the last word is written; that edge moves to DONE.
    assign word_wr   = (state_q == ST_EXPAND) && (i_q != total);

    assign w_prev   = w[i_q - 6'd1];
    assign w_back   = w[i_q - {2'b00, nk_q}];
    assign rot_prev = {w_prev[23:0], w_prev[31:24]};
    assign sub_in   = (mod_q == 3'd0) ? rot_prev : w_prev;

    aes_subword u_subword (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    always_comb begin
        t_word = w_prev;
        if (mod_q == 3'd0)
            t_word = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && mod_q == 3'd4)
            t_word = sub_out;
    end

    assign new_word = w_back ^ t_word;

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_acc) state_d = ST_EXPAND;
            ST_EXPAND:        if (i_q == total) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == ST_EXPAND);
        ready = (state_q == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            nk_q    <= 4'd0;
            nr_q    <= 4'd0;
            i_q     <= 6'd0;
            mod_q   <= 3'd0;
            rcon_q  <= 8'h00;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= start && (state_q != ST_EXPAND) && !len_ok;
            if (start_acc) begin
                nk_q   <= nk_of(key_len);
                nr_q   <= nr_of(key_len);
                i_q    <= {2'b00, nk_of(key_len)};
                mod_q  <= 3'd0;
                rcon_q <= 8'h01;
            end else if (word_wr) begin
                i_q   <= i_q + 6'd1;
                mod_q <= ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
                if (mod_q == 3'd0)
                    rcon_q <= xtime(rcon_q);
            end
        end
    end

    // Word store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            for (int j = 0; j < MAX_NK; j++)
                if (j < int'(nk_of(key_len)))
                    w[6'(j)] <= key_in[MAX_KEY_BITS-1-32*j -: 32];
        end else if (word_wr) begin
            w[i_q] <= new_word;
        end
    end

    // A read on the start edge sees the store as invalid, so old keys never leak.
    assign rd_ok   = rd_en && (state_q == ST_DONE) && !start_acc && (rd_round <= nr_q);
    assign rd_eff  = rd_dir ? (nr_q - rd_round) : rd_round;
    assign rd_base = {rd_eff, 2'b00};

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok)
                rd_key <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
        end
    end

    assign nr = nr_q;

endmodule

// File: tb/tb_aes_key_schedule_multi.sv
module tb_aes_key_schedule_multi;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key_in = '0;
    logic         busy, ready, cfg_err;
    logic [3:0]   nr;
    logic         rd_en = 1'b0;
    logic         rd_dir = 1'b0;
    logic [3:0]   rd_round = 4'd0;
    logic [127:0] rd_key;
    logic         rd_valid;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [191:0] KEY_C2  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] C2_K12  = 128'ha4970a331a78dc09c418c271e3a41d5d;
    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_K1   = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_K14  = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    aes_key_schedule_multi #(.MAX_KEY_BITS(256), .ROUND_BITS(128)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .ready    (ready),
        .cfg_err  (cfg_err),
        .nr       (nr),
        .rd_en    (rd_en),
        .rd_dir   (rd_dir),
        .rd_round (rd_round),
        .rd_key   (rd_key),
        .rd_valid (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic [1:0] len, input logic [255:0] key);
        @(negedge clk);
        start = 1'b1;
        key_len = len;
        key_in = key;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges counted after the start edge until ready; -1 when the bound expires.
    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!ready) cyc = -1;
    endtask

    task automatic do_read(input logic dir, input logic [3:0] rnd,
                           output logic v, output logic [127:0] k);
        @(negedge clk);
        rd_en = 1'b1;
        rd_dir = dir;
        rd_round = rnd;
        @(posedge clk);
        #1;
        v = rd_valid;
        k = rd_key;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        logic v;
        logic [127:0] k;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, ready, cfg_err, rd_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, ready, cfg_err, rd_valid});
        end
        checks++;
        if (nr !== 4'd0 || rd_key !== 128'h0) begin
            errors++;
            $display("FAIL reset_nr_key: got nr=%0d key=%h expected 0/0", nr, rd_key);
        end
        @(negedge clk);
        rst = 1'b1;
        do_read(1'b0, 4'd0, v, k);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL read_before_start: got rd_valid=%b expected 0", v);
        end
    endtask

    task automatic test_aes128();
        int cyc;
        logic v;
        logic [127:0] k;
        do_start(2'b00, {KEY_A1, 128'h0});
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0 || nr !== 4'd10) begin
            errors++;
            $display("FAIL a1_after_start: got busy=%b ready=%b nr=%0d expected 1/0/10", busy, ready, nr);
        end
        wait_ready(cyc);
        checks++;
        if (cyc !== 41) begin
            errors++;
            $display("FAIL a1_latency: got %0d expected 41", cyc);
        end
        do_read(1'b0, 4'd10, v, k);
        checks++;
        if (v !== 1'b1 || k !== A1_K10) begin
            errors++;
            $display("FAIL a1_k10: got v=%b %h expected 1 %h", v, k, A1_K10);
        end
        do_read(1'b0, 4'd1, v, k);
        checks++;
        if (v !== 1'b1 || k !== A1_K1) begin
            errors++;
            $display("FAIL a1_k1: got v=%b %h expected 1 %h", v, k, A1_K1);
        end
        do_read(1'b0, 4'd0, v, k);
        checks++;
        if (v !== 1'b1 || k !== KEY_A1) begin
            errors++;
            $display("FAIL a1_k0: got v=%b %h expected 1 %h", v, k, KEY_A1);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_decrypt_order();
        int cyc;
        logic v;
        logic [127:0] k;
        do_start(2'b00, {KEY_C1, 128'h0});
        wait_ready(cyc);
        checks++;
        if (cyc !== 41) begin
            errors++;
            $display("FAIL c1_latency: got %0d expected 41", cyc);
        end
        do_read(1'b1, 4'd0, v, k);
        checks++;
        if (v !== 1'b1 || k !== C1_K10) begin
            errors++;
            $display("FAIL c1_dec_r0: got v=%b %h expected 1 %h", v, k, C1_K10);
        end
        do_read(1'b1, 4'd10, v, k);
        checks++;
        if (v !== 1'b1 || k !== KEY_C1) begin
            errors++;
            $display("FAIL c1_dec_r10: got v=%b %h expected 1 %h", v, k, KEY_C1);
        end
        do_read(1'b1, 4'd11, v, k);
        checks++;
        if (v !== 1'b0 || k !== KEY_C1) begin
            errors++;
            $display("FAIL c1_dec_r11: got v=%b %h expected 0 %h", v, k, KEY_C1);
        end
    endtask

    task automatic test_aes192();
        int cyc;
        logic v;
        logic [127:0] k;
        do_start(2'b01, {KEY_C2, 64'h0});
        wait_ready(cyc);
        checks++;
        if (cyc !== 47 || nr !== 4'd12) begin
            errors++;
            $display("FAIL c2_latency_nr: got %0d nr=%0d expected 47 nr=12", cyc, nr);
        end
        do_read(1'b0, 4'd12, v, k);
        checks++;
        if (v !== 1'b1 || k !== C2_K12) begin
            errors++;
            $display("FAIL c2_k12: got v=%b %h expected 1 %h", v, k, C2_K12);
        end
        do_read(1'b0, 4'd13, v, k);
        checks++;
        if (v !== 1'b0 || k !== C2_K12) begin
            errors++;
            $display("FAIL c2_r13_invalid: got v=%b %h expected 0 %h", v, k, C2_K12);
        end
        do_read(1'b1, 4'd12, v, k);
        checks++;
        if (v !== 1'b1 || k !== KEY_C2[191:64]) begin
            errors++;
            $display("FAIL c2_dec_r12: got v=%b %h expected 1 %h", v, k, KEY_C2[191:64]);
        end
    endtask

    task automatic test_aes256();
        int cyc;
        logic v;
        logic [127:0] k;
        do_start(2'b10, KEY_C3);
        wait_ready(cyc);
        checks++;
        if (cyc !== 53 || nr !== 4'd14) begin
            errors++;
            $display("FAIL c3_latency_nr: got %0d nr=%0d expected 53 nr=14", cyc, nr);
        end
        do_read(1'b0, 4'd14, v, k);
        checks++;
        if (v !== 1'b1 || k !== C3_K14) begin
            errors++;
            $display("FAIL c3_k14: got v=%b %h expected 1 %h", v, k, C3_K14);
        end
        do_read(1'b0, 4'd1, v, k);
        checks++;
        if (v !== 1'b1 || k !== C3_K1) begin
            errors++;
            $display("FAIL c3_k1: got v=%b %h expected 1 %h", v, k, C3_K1);
        end
    endtask

    task automatic test_cfg_err();
        logic v;
        logic [127:0] k;
        do_start(2'b11, {KEY_A1, 128'h0});
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || ready !== 1'b1 || nr !== 4'd14) begin
            errors++;
            $display("FAIL cfg_err_pulse: got err=%b busy=%b ready=%b nr=%0d expected 1/0/1/14",
                     cfg_err, busy, ready, nr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_one_cycle: got %b expected 0", cfg_err);
        end
        do_read(1'b1, 4'd0, v, k);
        checks++;
        if (v !== 1'b1 || k !== C3_K14) begin
            errors++;
            $display("FAIL cfg_err_keys_kept: got v=%b %h expected 1 %h", v, k, C3_K14);
        end
    endtask

    task automatic test_restart();
        int cyc;
        logic v;
        logic [127:0] k;
        @(negedge clk);
        start = 1'b1;
        key_len = 2'b00;
        key_in = {KEY_A1, 128'h0};
        rd_en = 1'b1;
        rd_dir = 1'b0;
        rd_round = 4'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_drop: got valid=%b ready=%b busy=%b expected 0/0/1",
                     rd_valid, ready, busy);
        end
        wait_ready(cyc);
        do_read(1'b0, 4'd10, v, k);
        checks++;
        if (cyc !== 41 || v !== 1'b1 || k !== A1_K10) begin
            errors++;
            $display("FAIL restart_k10: got cyc=%0d v=%b %h expected 41 1 %h", cyc, v, k, A1_K10);
        end
    endtask

    task automatic test_start_mid_expand();
        int cyc;
        logic v;
        logic [127:0] k;
        do_start(2'b00, {KEY_C1, 128'h0});
        repeat (9) @(posedge clk);
        do_start(2'b10, KEY_C3);
        checks++;
        if (busy !== 1'b1 || nr !== 4'd10) begin
            errors++;
            $display("FAIL mid_start_ignored: got busy=%b nr=%0d expected 1/10", busy, nr);
        end
        wait_ready(cyc);
        checks++;
        if (cyc < 0 || cyc + 10 !== 41) begin
            errors++;
            $display("FAIL mid_start_latency: got %0d expected 41", cyc + 10);
        end
        do_read(1'b0, 4'd10, v, k);
        checks++;
        if (v !== 1'b1 || k !== C1_K10) begin
            errors++;
            $display("FAIL mid_start_key: got v=%b %h expected 1 %h", v, k, C1_K10);
        end
    endtask

    task automatic test_reset_mid_expand();
        logic v;
        logic [127:0] k;
        do_start(2'b10, KEY_C3);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || nr !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got busy=%b ready=%b nr=%0d expected 0/0/0", busy, ready, nr);
        end
        repeat (5) @(posedge clk);
        do_read(1'b0, 4'd0, v, k);
        checks++;
        if (v !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_read: got v=%b busy=%b ready=%b expected 0/0/0", v, busy, ready);
        end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_decrypt_order();
        test_aes192();
        test_aes256();
        test_cfg_err();
        test_restart();
        test_start_mid_expand();
        test_reset_mid_expand();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
